// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer and valid/ready handshake on both sides.
// in_ready is registered, so the stall path from out_ready to in_ready is cut at this stage.
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | no entry held, out_valid low
// HALF  | head entry in main register
// FULL  | head in main, next entry in skid, in_ready low
module pipe_stage_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = (state_q != EMPTY) & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // An emit in this cycle still completes downstream; any accept is dropped.
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = HALF;
                        main_d  = in_data;
                    end
                end
                HALF: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_d = HALF;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        in_ready  = in_ready_q;
        count     = logic'(state_q[1]) ? 2'd2 : {1'b0, state_q[0]};
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed cases plus random back-pressure, with a queue
// scoreboard that mirrors the expected occupancy and delivery order.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_acc  = 0;
    bit          mon_en = 1'b0;
    logic [31:0] sb_q[$];
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev = '0;

    pipe_stage_skid #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the queue models the stage contents between edges.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] exp_d;
            chk("count", {30'd0, count}, sb_q.size());
            chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
            if (hold_prev)
                chk("hold_stable", out_data, data_prev);
            hold_prev = out_valid && !out_ready && reset && !flush;
            data_prev = out_data;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("underflow", 32'd1, 32'd0);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("order", out_data, exp_d);
                end
            end
            if (!reset || flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                n_acc++;
            end
        end
    end

    initial begin
        int start;
        int cyc;
        logic r_before;

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b1;

        // reset held for two edges with a valid input offered
        for (int i = 0; i < 2; i++) begin
            tick();
            mon_en = 1'b1;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_count", {30'd0, count}, 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("rel_data", out_data, 32'hDEADBEEF);
        chk("rel_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();

        // streaming with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            tick();
            chk("stream_data", out_data, i);
            chk("stream_count", {30'd0, count}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {30'd0, count}, 32'd0);

        // stall and skid
        in_valid = 1'b1; in_data = 32'hA;
        tick();
        out_ready = 1'b0; in_data = 32'hB;
        tick();
        in_data = 32'hC;
        tick();
        chk("stall_count", {30'd0, count}, 32'd2);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_hold_a", out_data, 32'hA);
        tick();
        chk("stall_hold_a2", out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("release_b", out_data, 32'hB);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("release_c", out_data, 32'hC);
        in_valid = 1'b0;
        tick();
        chk("release_empty", {30'd0, count}, 32'd0);

        // flush while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h10;
        tick();
        in_data = 32'h11;
        tick();
        chk("fill_count", {30'd0, count}, 32'd2);
        flush = 1'b1; in_data = 32'h12;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_data", out_data, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("flush_still_empty", {31'd0, out_valid}, 32'd0);

        // simultaneous accept and emit in HALF
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5;
        tick();
        out_ready = 1'b1; in_data = 32'h6;
        tick();
        chk("half_data", out_data, 32'h6);
        chk("half_count", {30'd0, count}, 32'd1);
        in_valid = 1'b0;
        tick();

        // random back-pressure; also probe out_ready -> in_ready for a combinational path
        start = n_acc;
        cyc   = 0;
        while ((n_acc - start) < 1000 && cyc < 20000) begin
            r_before  = in_ready;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ~out_ready;
            #1;
            chk("no_comb_path", {31'd0, in_ready}, {31'd0, r_before});
            out_ready = 1'($urandom_range(0, 3) != 0 ? $urandom_range(0, 1) : 0);
            tick();
            cyc++;
        end
        chk("random_budget", {31'd0, (n_acc - start) >= 1000}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a two-entry skid buffer and a valid/ready handshake on both sides. It is the successor to the plain enable/flush stage register. Stall back-pressure is expressed through `out_ready` instead of a global enable. `in_ready` is a flop output, so stall paths between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) are cut with no combinational through-path. Flush zeroes the stage, which inserts a bubble, in the same way as the current stage registers.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-low; sampled only on the `clk` rising edge; clears the whole stage.
- `flush`  in  1  synchronous, active-high; discards all held entries.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  head entry (main register).
- `count`  out  2  occupancy: 0, 1 or 2.

## Operation
- accept = `in_valid & in_ready`; emit = `out_valid & out_ready`.
- Storage: main register (drives `out_data`) and skid register.
- States: EMPTY (count 0), HALF (count 1), FULL (count 2).
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL), held in a flop updated from the next state.
- EMPTY:
  - accept → HALF, main ← `in_data`.
- HALF:
  - accept & emit → HALF, main ← `in_data`.
  - accept & !emit → FULL, skid ← `in_data`.
  - !accept & emit → EMPTY.
  - Otherwise hold.
- FULL:
  - emit → HALF, main ← skid.
  - No accept is possible because `in_ready` = 0.
- Ordering: entries leave in arrival order. No entry is lost or duplicated.
- Priority: `reset` low > `flush` > handshake.
- Flush:
  - State → EMPTY; main and skid ← 0; `in_ready` ← 1.
  - An accept in the flush cycle is discarded.
  - An emit in the flush cycle still completes downstream, because the downstream side samples it in that cycle.
- Reset (`reset` = 0 at an edge): identical effect to flush.
- Reset values: `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `count` = 0, skid = 0.
- `out_data` is held stable while `out_valid & !out_ready`, including when the skid register is written.
- Data registers that are not written keep their value. No X propagation after reset.

## Timing
- Latency: data accepted at edge N is on `out_data` with `out_valid` = 1 after edge N. This is one cycle.
- Throughput: one transfer per cycle when `out_ready` stays high. The skid register is never used in that case.
- Stall:
  - When `out_ready` drops, one more entry is absorbed into the skid register.
  - `in_ready` falls on the following edge.
- Release from FULL:
  - The first edge with `out_ready` = 1 moves skid to main.
  - `in_ready` rises after that same edge.
  - An accept is possible from the next cycle.
- `in_ready` and `out_valid` depend only on flops.
- `out_ready` → `in_ready` has no combinational path.
- `flush` or `reset` asserted while FULL: both entries drop in one edge; the stage is EMPTY next cycle.
- Simultaneous `flush` and `reset` low: treated as reset, with the same effect.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset` = 0 for 2 edges with `in_valid` = 1, `in_data` = 0xDEADBEEF, then release.
  - Required: `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `count` = 0 throughout the reset cycles.
  - Required: 0xDEADBEEF appears on `out_data` one edge after release.
- Streaming:
  - Stimulus: `out_ready` = 1; send 0x1, 0x2, 0x3, 0x4 on consecutive cycles.
  - Required: outputs are 0x1..0x4 on consecutive cycles, each 1 cycle after input; `count` never exceeds 1.
- Stall and skid:
  - Stimulus: send 0xA, 0xB, 0xC back-to-back while `out_ready` = 0 from the second cycle.
  - Required: `count` reaches 2, `in_ready` = 0, `out_data` = 0xA holds, and 0xC is not accepted.
  - Stimulus: raise `out_ready`.
  - Required: output order 0xA, 0xB, 0xC with no gaps after the first emit.
- Flush while FULL:
  - Stimulus: fill with 0x10, 0x11; pulse `flush` with `in_valid` = 1, `in_data` = 0x12.
  - Required: next cycle `count` = 0, `out_valid` = 0, `out_data` = 0, `in_ready` = 1; 0x12 never emerges.
- Simultaneous accept and emit in HALF:
  - Stimulus: hold 0x5; same cycle `out_ready` = 1, `in_data` = 0x6.
  - Required: 0x5 emitted, `out_data` becomes 0x6, `count` stays 1.
- Randomised back-pressure:
  - Stimulus: 1000 transfers with random `in_valid`/`out_ready`.
  - Required: scoreboard shows in-order, lossless delivery; `in_ready` never depends combinationally on `out_ready`.
